// File: rtl/psum_mem_ctrl_if.sv
// Core (memctrl0) and host readout signals of the partial-sum buffer.
interface psum_mem_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] memctrl0_wadd;
  logic                  memctrl0_wren;
  logic [DATA_WIDTH-1:0] memctrl0_idat;
  logic [ADDR_WIDTH-1:0] memctrl0_radd;
  logic                  memctrl0_rden;
  logic [DATA_WIDTH-1:0] memctrl0_odat;
  logic                  memctrl0_oval;
  logic [ADDR_WIDTH-1:0] host_radd;
  logic                  host_rden;
  logic                  host_rgnt;
  logic [DATA_WIDTH-1:0] host_odat;
  logic                  host_oval;

  // Requester side (core + host glue)
  modport master (
    output memctrl0_wadd, memctrl0_wren, memctrl0_idat, memctrl0_radd, memctrl0_rden,
    output host_radd, host_rden,
    input  memctrl0_odat, memctrl0_oval, host_rgnt, host_odat, host_oval
  );

  // Buffer/controller side
  modport slave (
    input  memctrl0_wadd, memctrl0_wren, memctrl0_idat, memctrl0_radd, memctrl0_rden,
    input  host_radd, host_rden,
    output memctrl0_odat, memctrl0_oval, host_rgnt, host_odat, host_oval
  );
endinterface

// File: rtl/psum_mem_ctrl.sv
// Partial-sum buffer: pipelined core reads, same-cycle core writes, bulk zero-clear
// engine and a low-priority host readout port sharing the single read port.
module psum_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 4096,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  psum_mem_ctrl_if.slave       bus,
  input  logic                 i_clr_start,
  input  logic                 i_err_clr,
  output logic [31:0]          o_status
);

  localparam int unsigned IW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DepthA = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [IW-1:0] LastIdx = IW'(MEM_DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                r_state, w_state_nxt;
  logic [IW-1:0]         r_clr_cnt;
  logic                  w_clr_busy;
  logic                  w_clr_we;
  logic                  w_idle;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_wadd_ok, w_radd_ok, w_hadd_ok;
  logic                  w_host_gnt;
  logic                  w_mem_we;
  logic [IW-1:0]         w_mem_widx;
  logic [DATA_WIDTH-1:0] w_mem_wdat;
  logic [ADDR_WIDTH-1:0] w_raddr;
  logic                  w_raddr_ok;
  logic [IW-1:0]         w_ridx;
  logic [DATA_WIDTH-1:0] w_rd_dat;
  logic                  w_oor_evt, w_busy_evt;

  logic                  r_err_oor, r_err_busy;
  logic                  r_cv [RD_LATENCY];
  logic [DATA_WIDTH-1:0] r_cd [RD_LATENCY];
  logic                  r_hv [RD_LATENCY];
  logic [DATA_WIDTH-1:0] r_hd [RD_LATENCY];

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= StIdle;
    else      r_state <= w_state_nxt;
  end

  // FSM next state: start pulses are only honoured in IDLE
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (i_clr_start) w_state_nxt = StClear;
      StClear: if (r_clr_cnt == LastIdx) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_clr_busy = (r_state == StClear);
    w_clr_we   = (r_state == StClear);
    w_idle     = (r_state == StIdle);
  end

  // Clear counter: armed to 0 on start, walks the buffer while clearing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      r_clr_cnt <= '0;
    else if (w_idle && i_clr_start) r_clr_cnt <= '0;
    else if (w_clr_we)              r_clr_cnt <= r_clr_cnt + 1'b1;
  end

  // Address decode, arbitration and write/read port muxing
  always_comb begin
    w_wadd_ok  = (bus.memctrl0_wadd < DepthA);
    w_radd_ok  = (bus.memctrl0_radd < DepthA);
    w_hadd_ok  = (bus.host_radd < DepthA);
    // Core always wins the read port; host only in IDLE
    w_host_gnt = bus.host_rden & ~bus.memctrl0_rden & w_idle;

    w_mem_we   = w_clr_we | (w_idle & bus.memctrl0_wren & w_wadd_ok);
    w_mem_widx = w_clr_we ? r_clr_cnt : bus.memctrl0_wadd[IW-1:0];
    w_mem_wdat = w_clr_we ? '0 : bus.memctrl0_idat;

    w_raddr    = bus.memctrl0_rden ? bus.memctrl0_radd : bus.host_radd;
    w_raddr_ok = bus.memctrl0_rden ? w_radd_ok : w_hadd_ok;
    w_ridx     = w_raddr[IW-1:0];

    // Write-first bypass; out-of-range or clearing reads return zero
    if (!(w_idle && w_raddr_ok))                   w_rd_dat = '0;
    else if (w_mem_we && (w_mem_widx == w_ridx))   w_rd_dat = w_mem_wdat;
    else                                           w_rd_dat = r_mem[w_ridx];

    w_oor_evt  = (bus.memctrl0_wren & ~w_wadd_ok) | (bus.memctrl0_rden & ~w_radd_ok) |
                 (w_host_gnt & ~w_hadd_ok);
    w_busy_evt = w_clr_busy & (bus.memctrl0_wren | bus.memctrl0_rden);
  end

  // Storage: single write port, contents survive reset
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_widx] <= w_mem_wdat;
  end

  // Read pipelines; data stages only load on valid so outputs hold their last value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_cv[i] <= 1'b0;
        r_cd[i] <= '0;
        r_hv[i] <= 1'b0;
        r_hd[i] <= '0;
      end
    end else begin
      r_cv[0] <= bus.memctrl0_rden;
      r_hv[0] <= w_host_gnt;
      if (bus.memctrl0_rden) r_cd[0] <= w_rd_dat;
      if (w_host_gnt)        r_hd[0] <= w_rd_dat;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_cv[i] <= r_cv[i-1];
        r_hv[i] <= r_hv[i-1];
        if (r_cv[i-1]) r_cd[i] <= r_cd[i-1];
        if (r_hv[i-1]) r_hd[i] <= r_hd[i-1];
      end
    end
  end

  // Sticky error bits; a same-cycle event beats the clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_oor  <= 1'b0;
      r_err_busy <= 1'b0;
    end else begin
      if (w_oor_evt)      r_err_oor <= 1'b1;
      else if (i_err_clr) r_err_oor <= 1'b0;
      if (w_busy_evt)     r_err_busy <= 1'b1;
      else if (i_err_clr) r_err_busy <= 1'b0;
    end
  end

  // Output drive
  always_comb begin
    bus.memctrl0_oval = r_cv[RD_LATENCY-1];
    bus.memctrl0_odat = r_cd[RD_LATENCY-1];
    bus.host_oval     = r_hv[RD_LATENCY-1];
    bus.host_odat     = r_hd[RD_LATENCY-1];
    bus.host_rgnt     = w_host_gnt;
    o_status          = {29'b0, r_err_busy, r_err_oor, w_clr_busy};
  end

endmodule

// File: tb/tb_psum_mem_ctrl.sv
// Self-checking bench for psum_mem_ctrl: directed scenarios plus a randomized
// run compared against a word-array/queue reference model.
module tb_psum_mem_ctrl;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_start;
  logic        err_clr;
  logic [31:0] status;
  int          n_vec = 0;
  int          n_err = 0;

  psum_mem_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  psum_mem_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .RD_LATENCY(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .i_clr_start(clr_start),
    .i_err_clr  (err_clr),
    .o_status   (status)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] dat;
  } exp_t;

  logic [31:0] model_mem [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.memctrl0_wren = 1'b0;
    bus.memctrl0_wadd = '0;
    bus.memctrl0_idat = '0;
    bus.memctrl0_rden = 1'b0;
    bus.memctrl0_radd = '0;
    bus.host_rden     = 1'b0;
    bus.host_radd     = '0;
    clr_start         = 1'b0;
    err_clr           = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    bus.memctrl0_wren = 1'b1;
    bus.memctrl0_wadd = a;
    bus.memctrl0_idat = d;
    tick();
    bus.memctrl0_wren = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic early, output logic v,
                         output logic [31:0] d);
    bus.memctrl0_rden = 1'b1;
    bus.memctrl0_radd = a;
    tick();
    bus.memctrl0_rden = 1'b0;
    early = bus.memctrl0_oval;
    tick();
    v = bus.memctrl0_oval;
    d = bus.memctrl0_odat;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    #2;
    n_vec++;
    if (status !== 32'h0) begin
      n_err++; $display("FAIL reset_status got %h want %h", status, 32'h0);
    end
    n_vec++;
    if (bus.memctrl0_oval !== 1'b0 || bus.host_oval !== 1'b0) begin
      n_err++; $display("FAIL reset_oval got %b/%b want 0/0", bus.memctrl0_oval, bus.host_oval);
    end
    n_vec++;
    if (bus.host_rgnt !== 1'b0) begin
      n_err++; $display("FAIL reset_rgnt got %b want 0", bus.host_rgnt);
    end
    #1 rst = 1'b1;
    tick();
  endtask

  task automatic test_clear();
    int cnt;
    logic e, v;
    logic [31:0] d;
    logic [31:0] addrs [3];
    addrs[0] = 0; addrs[1] = 100; addrs[2] = 4095;
    for (int i = 0; i < 3; i++) do_write(addrs[i], 32'hC0DE_0000 + addrs[i] + 1);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    cnt = 0;
    while (status[0] === 1'b1 && cnt < 5000) begin
      cnt++;
      tick();
    end
    n_vec++;
    if (cnt != DEPTH) begin
      n_err++; $display("FAIL clear_busy_cycles got %0d want %0d", cnt, DEPTH);
    end
    for (int i = 0; i < 3; i++) begin
      do_read(addrs[i], e, v, d);
      n_vec++;
      if (e !== 1'b0 || v !== 1'b1) begin
        n_err++; $display("FAIL clear_read_lat addr %0d got early=%b v=%b want 0/1", addrs[i], e, v);
      end
      n_vec++;
      if (d !== 32'h0) begin
        n_err++; $display("FAIL clear_read_data addr %0d got %h want 0", addrs[i], d);
      end
    end
    n_vec++;
    if (status !== 32'h0) begin
      n_err++; $display("FAIL clear_status got %h want 0", status);
    end
  endtask

  task automatic test_write_first();
    do_write(5, 32'h11);
    bus.memctrl0_wren = 1'b1; bus.memctrl0_wadd = 5; bus.memctrl0_idat = 32'h22;
    bus.memctrl0_rden = 1'b1; bus.memctrl0_radd = 5;
    tick();
    bus.memctrl0_wren = 1'b0;
    tick();
    bus.memctrl0_rden = 1'b0;
    n_vec++;
    if (bus.memctrl0_oval !== 1'b1 || bus.memctrl0_odat !== 32'h22) begin
      n_err++; $display("FAIL wf_same_cycle got v=%b d=%h want 1/22", bus.memctrl0_oval,
                        bus.memctrl0_odat);
    end
    tick();
    n_vec++;
    if (bus.memctrl0_oval !== 1'b1 || bus.memctrl0_odat !== 32'h22) begin
      n_err++; $display("FAIL wf_next_cycle got v=%b d=%h want 1/22", bus.memctrl0_oval,
                        bus.memctrl0_odat);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic        ev;
    logic [31:0] ed;
    for (int i = 0; i < 8; i++) do_write(i, 32'hA0 + i);
    for (int i = 0; i < 10; i++) begin
      bus.memctrl0_rden = (i < 8);
      bus.memctrl0_radd = i;
      tick();
      ev = (i >= 1 && i <= 8);
      ed = 32'hA0 + i - 1;
      n_vec++;
      if (bus.memctrl0_oval !== ev || (ev && bus.memctrl0_odat !== ed)) begin
        n_err++; $display("FAIL b2b_cycle%0d got v=%b d=%h want v=%b d=%h", i,
                          bus.memctrl0_oval, bus.memctrl0_odat, ev, ed);
      end
    end
    bus.memctrl0_rden = 1'b0;
  endtask

  task automatic test_oor();
    logic e, v;
    logic [31:0] d;
    do_write(904, 32'h0000_0904);
    do_write(5000, 32'h55);
    do_read(5000, e, v, d);
    n_vec++;
    if (v !== 1'b1 || d !== 32'h0) begin
      n_err++; $display("FAIL oor_read got v=%b d=%h want 1/0", v, d);
    end
    n_vec++;
    if (status !== 32'h2) begin
      n_err++; $display("FAIL oor_status got %h want 2", status);
    end
    do_read(904, e, v, d);
    n_vec++;
    if (d !== 32'h0000_0904) begin
      n_err++; $display("FAIL oor_alias got %h want 904", d);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_vec++;
    if (status !== 32'h0) begin
      n_err++; $display("FAIL err_clr_status got %h want 0", status);
    end
  endtask

  task automatic test_host_arb();
    do_write(3, 32'h33);
    bus.host_rden = 1'b1;
    bus.host_radd = 3;
    for (int i = 0; i < 4; i++) begin
      bus.memctrl0_rden = 1'b1;
      bus.memctrl0_radd = 0;
      #1;
      n_vec++;
      if (bus.host_rgnt !== 1'b0) begin
        n_err++; $display("FAIL host_starve_%0d got %b want 0", i, bus.host_rgnt);
      end
      tick();
    end
    bus.memctrl0_rden = 1'b0;
    #1;
    n_vec++;
    if (bus.host_rgnt !== 1'b1) begin
      n_err++; $display("FAIL host_grant got %b want 1", bus.host_rgnt);
    end
    tick();
    bus.host_rden = 1'b0;
    n_vec++;
    if (bus.host_oval !== 1'b0) begin
      n_err++; $display("FAIL host_early got %b want 0", bus.host_oval);
    end
    tick();
    n_vec++;
    if (bus.host_oval !== 1'b1 || bus.host_odat !== 32'h33) begin
      n_err++; $display("FAIL host_data got v=%b d=%h want 1/33", bus.host_oval, bus.host_odat);
    end
    tick();
    n_vec++;
    if (bus.host_oval !== 1'b0) begin
      n_err++; $display("FAIL host_pulse got %b want 0", bus.host_oval);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 32'(DEPTH + $urandom_range(0, 15));
    return 32'($urandom_range(0, 15));
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a, input logic we,
                                          input logic [31:0] wa, input logic [31:0] wd);
    if (a >= DEPTH) return 32'h0;
    if (we && wa == a) return wd;
    return model_mem[a];
  endfunction

  task automatic test_random();
    exp_t        cq[$];
    exp_t        hq[$];
    exp_t        ent;
    int          cyc;
    logic        exp_oor;
    logic        ev;
    logic        egnt;
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = $urandom();
      do_write(i, model_mem[i]);
    end
    tick();
    cyc = 0;
    exp_oor = 1'b0;
    for (int c = 0; c < 402; c++) begin
      if (c < 400) begin
        bus.memctrl0_wren = 1'($urandom_range(0, 1));
        bus.memctrl0_wadd = rand_addr();
        bus.memctrl0_idat = $urandom();
        bus.memctrl0_rden = 1'($urandom_range(0, 1));
        bus.memctrl0_radd = rand_addr();
        bus.host_rden     = 1'($urandom_range(0, 1));
        bus.host_radd     = rand_addr();
      end else begin
        idle_inputs();
      end
      egnt = bus.host_rden & ~bus.memctrl0_rden;
      #1;
      n_vec++;
      if (bus.host_rgnt !== egnt) begin
        n_err++; $display("FAIL rand_rgnt cyc %0d got %b want %b", cyc, bus.host_rgnt, egnt);
      end
      if (bus.memctrl0_rden) begin
        ent.due = cyc + 2;
        ent.dat = model_rd(bus.memctrl0_radd, bus.memctrl0_wren, bus.memctrl0_wadd,
                           bus.memctrl0_idat);
        cq.push_back(ent);
        if (bus.memctrl0_radd >= DEPTH) exp_oor = 1'b1;
      end
      if (egnt) begin
        ent.due = cyc + 2;
        ent.dat = model_rd(bus.host_radd, bus.memctrl0_wren, bus.memctrl0_wadd,
                           bus.memctrl0_idat);
        hq.push_back(ent);
        if (bus.host_radd >= DEPTH) exp_oor = 1'b1;
      end
      if (bus.memctrl0_wren) begin
        if (bus.memctrl0_wadd < DEPTH) model_mem[bus.memctrl0_wadd[3:0]] = bus.memctrl0_idat;
        else exp_oor = 1'b1;
      end
      tick();
      cyc++;
      ev = (cq.size() > 0) && (cq[0].due == cyc);
      n_vec++;
      if (bus.memctrl0_oval !== ev || (ev && bus.memctrl0_odat !== cq[0].dat)) begin
        n_err++; $display("FAIL rand_core cyc %0d got v=%b d=%h want v=%b d=%h", cyc,
                          bus.memctrl0_oval, bus.memctrl0_odat, ev, ev ? cq[0].dat : 32'h0);
      end
      if (ev) void'(cq.pop_front());
      ev = (hq.size() > 0) && (hq[0].due == cyc);
      n_vec++;
      if (bus.host_oval !== ev || (ev && bus.host_odat !== hq[0].dat)) begin
        n_err++; $display("FAIL rand_host cyc %0d got v=%b d=%h want v=%b d=%h", cyc,
                          bus.host_oval, bus.host_odat, ev, ev ? hq[0].dat : 32'h0);
      end
      if (ev) void'(hq.pop_front());
    end
    n_vec++;
    if (status !== {30'b0, exp_oor, 1'b0}) begin
      n_err++; $display("FAIL rand_status got %h want %h", status, {30'b0, exp_oor, 1'b0});
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_clear_abort();
    logic e, v;
    logic [31:0] d;
    do_write(4000, 32'hDEAD);
    do_write(4001, 32'h4001);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (k == 3) begin
        bus.memctrl0_wren = 1'b1; bus.memctrl0_wadd = 10; bus.memctrl0_idat = 32'hBEEF;
      end
      if (k == 4) begin
        bus.memctrl0_wren = 1'b1; bus.memctrl0_wadd = 4001; bus.memctrl0_idat = 32'hBEEF;
      end
      if (k == 5) begin
        bus.memctrl0_rden = 1'b1; bus.memctrl0_radd = 4000;
      end
      tick();
      bus.memctrl0_wren = 1'b0;
      bus.memctrl0_rden = 1'b0;
      if (k == 3) begin
        n_vec++;
        if (status !== 32'h5) begin
          n_err++; $display("FAIL busy_status got %h want 5", status);
        end
      end
      if (k == 6) begin
        n_vec++;
        if (bus.memctrl0_oval !== 1'b1 || bus.memctrl0_odat !== 32'h0) begin
          n_err++; $display("FAIL busy_read got v=%b d=%h want 1/0", bus.memctrl0_oval,
                            bus.memctrl0_odat);
        end
      end
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (status !== 32'h0 || bus.memctrl0_oval !== 1'b0) begin
      n_err++; $display("FAIL abort_reset got st=%h v=%b want 0/0", status, bus.memctrl0_oval);
    end
    #1 rst = 1'b1;
    tick();
    do_read(4000, e, v, d);
    n_vec++;
    if (v !== 1'b1 || d !== 32'hDEAD) begin
      n_err++; $display("FAIL abort_keep got v=%b d=%h want 1/dead", v, d);
    end
    do_read(4001, e, v, d);
    n_vec++;
    if (d !== 32'h4001) begin
      n_err++; $display("FAIL busy_wr_drop got %h want 4001", d);
    end
    n_vec++;
    if (status !== 32'h0) begin
      n_err++; $display("FAIL abort_status got %h want 0", status);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_write_first();
    test_back_to_back();
    test_oor();
    test_host_arb();
    test_random();
    test_clear_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
